// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, frame bit levels and parity helper shared by the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  // Even parity of data, inverted for odd; callers zero-extend narrower words.
  function automatic logic parity_calc(input logic [31:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser for the serial line (resets to idle-high) plus falling-edge detect
//   clock_out  oversampled tick clock
//   nreset     asynchronous active-low reset
//   sdata_in   raw serial line, asynchronous to clock_out
//   rx_s       synchronised line
//   fall       high for one tick when rx_s goes from 1 to 0
module uart_rx_sync import uart_pkg::*; (
  input  logic clock_out,
  input  logic nreset,
  input  logic sdata_in,
  output logic rx_s,
  output logic fall
);
  // [0] metastability stage, [1] synchronised line, [2] previous synchronised value
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], sdata_in};
  always_ff @(posedge clock_out or negedge nreset)
    if (!nreset) sync_q <= {3{STOP_BIT}};
    else sync_q <= sync_d;
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, LSB-first frames to a valid/ready word interface
//   clock_out        tick clock at BAUDRATE*OVERSAMPLING
//   nreset           asynchronous active-low reset
//   sdata_rx_in      serial line, idle high
//   ready_rx_in      consumer accepts data_rx_out while valid_rx_out is high
//   data_rx_out      last good word, stable while valid_rx_out is high
//   valid_rx_out     word pending until handshake
//   frame_err_out    one-tick pulse, stop bit sampled low
//   parity_err_out   one-tick pulse, parity mismatch (tied 0 unless UART_RX_PARITY_EN)
//   overrun_err_out  one-tick pulse, good word overwrote an unaccepted one
//   busy_rx_out      receiver not idle
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx import uart_pkg::*; #(
  parameter int BYTESIZES = 8,
  parameter int OVERSAMPLING = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock_out,
  input  logic                 nreset,
  input  logic                 sdata_rx_in,
  input  logic                 ready_rx_in,
  output logic [BYTESIZES-1:0] data_rx_out,
  output logic                 valid_rx_out,
  output logic                 frame_err_out,
  output logic                 parity_err_out,
  output logic                 overrun_err_out,
  output logic                 busy_rx_out
);
  localparam int CW = $clog2(OVERSAMPLING);
  localparam int IW = $clog2(BYTESIZES + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(BYTESIZES - 1);
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BYTESIZES-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rx_s, fall, bit_end, stop_ok, good, pbad;
  uart_rx_sync u_sync (.clock_out, .nreset, .sdata_in(sdata_rx_in), .rx_s, .fall);
  assign bit_end = cnt_q == LAST;
`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d, perr_q, perr_d;
  assign pbad = pbad_q;
  assign parity_err_out = perr_q;
`else
  assign pbad = 1'b0;
  assign parity_err_out = 1'b0;
`endif
  always_ff @(posedge clock_out or negedge nreset)
    if (!nreset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fall ? START : IDLE;
      START:   if (cnt_q == HALF) state_d = rx_s == START_BIT ? DATA : IDLE;
`ifdef UART_RX_PARITY_EN
      DATA:    if (bit_end && idx_q == LAST_BIT) state_d = PARITY;
      PARITY:  if (bit_end) state_d = STOP;
`else
      DATA:    if (bit_end && idx_q == LAST_BIT) state_d = STOP;
`endif
      STOP:    if (bit_end) state_d = rx_s == STOP_BIT ? IDLE : BREAK;
      BREAK:   if (rx_s == STOP_BIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    // bit timing restarts at every state entry; IDLE keeps it parked at 0
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    idx_d = state_q != DATA ? '0 : bit_end ? idx_q + 1'b1 : idx_q;
    shift_d = (state_q == DATA && bit_end) ? {rx_s, shift_q[BYTESIZES-1:1]} : shift_q;
    stop_ok = state_q == STOP && bit_end && rx_s == STOP_BIT;
    good = stop_ok && !pbad;
    ferr_d = state_q == STOP && bit_end && rx_s != STOP_BIT;
    // a completion on the handshake tick replaces the accepted word without overrun
    valid_d = good || (valid_q && !ready_rx_in);
    ovr_d = good && valid_q && !ready_rx_in;
    data_d = good ? shift_q : data_q;
`ifdef UART_RX_PARITY_EN
    pbad_d = (state_q == PARITY && bit_end) ? rx_s != parity_calc(32'(shift_q), PARITY_ODD[0]) : pbad_q;
    perr_d = stop_ok && pbad_q;
`endif
  end
  always_ff @(posedge clock_out or negedge nreset)
    if (!nreset) begin
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q <= pbad_d;
      perr_q <= perr_d;
`endif
    end
  assign data_rx_out = data_q;
  assign valid_rx_out = valid_q;
  assign frame_err_out = ferr_q;
  assign overrun_err_out = ovr_q;
  assign busy_rx_out = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a frame-level reference model of uart_rx
module tb_uart_rx;
  localparam int BS = 8;
  localparam int OS = 16;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic clock_out = 0, nreset = 0, sdata_rx_in = 1, ready_rx_in = 0;
  logic [BS-1:0] data_rx_out;
  logic valid_rx_out, frame_err_out, parity_err_out, overrun_err_out, busy_rx_out;
  int checks = 0, failures = 0, cyc = 0;
  int ferr_n = 0, perr_n = 0, ovr_n = 0, m_ferr = 0, m_perr = 0, m_ovr = 0;
  int rise_cyc = -1, ferr_cyc = -1, perr_cyc = -1, ovr_cyc = -1;
  logic valid_prev = 0, m_pend = 0;
  logic [BS-1:0] m_word = 0, m_last = 0;
  logic [BS-1:0] got_q[$], exp_q[$];
  uart_rx #(.BYTESIZES(BS), .OVERSAMPLING(OS), .PARITY_ODD(PODD)) dut (
    .clock_out(clock_out), .nreset(nreset), .sdata_rx_in(sdata_rx_in), .ready_rx_in(ready_rx_in),
    .data_rx_out(data_rx_out), .valid_rx_out(valid_rx_out), .frame_err_out(frame_err_out),
    .parity_err_out(parity_err_out), .overrun_err_out(overrun_err_out), .busy_rx_out(busy_rx_out));
  always #5 clock_out = ~clock_out;
  always @(posedge clock_out) cyc <= cyc + 1;
  always @(negedge clock_out) begin
    if (valid_rx_out && ready_rx_in) got_q.push_back(data_rx_out);
    if (valid_rx_out && !valid_prev) rise_cyc <= cyc;
    valid_prev <= valid_rx_out;
    if (frame_err_out) begin ferr_n <= ferr_n + 1; ferr_cyc <= cyc; end
    if (parity_err_out) begin perr_n <= perr_n + 1; perr_cyc <= cyc; end
    if (overrun_err_out) begin ovr_n <= ovr_n + 1; ovr_cyc <= cyc; end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock_out);
    #1;
  endtask
  task automatic set_ready(input logic r);
    ready_rx_in = r;
    if (r && m_pend) begin exp_q.push_back(m_word); m_pend = 0; end
  endtask
  task automatic send_frame(input logic [BS-1:0] d, input logic stop, input logic par_bad, input int extra_low, output int c0);
    logic [BS+2:0] bits;
    bits = '0;
    bits[BS:1] = d;
    if (PAR != 0) begin
      bits[BS+1] = (^d) ^ (PODD != 0) ^ par_bad;
      bits[BS+2] = stop;
    end else bits[BS+1] = stop;
    c0 = cyc;
    for (int i = 0; i < BS + 2 + PAR; i++) begin sdata_rx_in = bits[i]; tick(OS); end
    if (extra_low > 0) begin sdata_rx_in = 0; tick(extra_low); end
    sdata_rx_in = 1;
    tick(4);
  endtask
  // outcome of a frame from its bits alone: event lands one tick after the mid-stop-bit sample
  task automatic model_frame(input logic [BS-1:0] d, input logic stop, input logic par_bad, input int c0);
    int t;
    t = c0 + 3 + OS / 2 + (BS + 1 + PAR) * OS;
    if (!stop) begin m_ferr++; chk("ferr_time", ferr_cyc, t); end
    else if (par_bad) begin m_perr++; chk("perr_time", perr_cyc, t); end
    else if (m_pend && !ready_rx_in) begin m_ovr++; m_word = d; m_last = d; chk("ovr_time", ovr_cyc, t); end
    else begin
      chk("valid_time", rise_cyc, t);
      m_last = d;
      if (ready_rx_in) exp_q.push_back(d);
      else begin m_pend = 1; m_word = d; end
    end
    chk("ferr_n", ferr_n, m_ferr);
    chk("perr_n", perr_n, m_perr);
    chk("ovr_n", ovr_n, m_ovr);
    chk("valid_lvl", valid_rx_out, m_pend);
    chk("data_hold", data_rx_out, m_last);
  endtask
  task automatic frame(input logic [BS-1:0] d, input logic stop, input logic par_bad);
    int c;
    send_frame(d, stop, par_bad, 0, c);
    model_frame(d, stop, par_bad, c);
  endtask
  initial begin
    int c;
    logic [BS-1:0] d;
    logic st, pb;
    tick(3);
    chk("rst_data", data_rx_out, 0);
    chk("rst_valid", valid_rx_out, 0);
    chk("rst_ferr", frame_err_out, 0);
    chk("rst_perr", parity_err_out, 0);
    chk("rst_ovr", overrun_err_out, 0);
    chk("rst_busy", busy_rx_out, 0);
    nreset = 1;
    tick(3);
    set_ready(1);
    frame(8'hA5, 1, 0);
    sdata_rx_in = 0;
    tick(4);
    chk("glitch_busy", busy_rx_out, 1);
    sdata_rx_in = 1;
    tick(30);
    chk("glitch_idle", busy_rx_out, 0);
    chk("glitch_valid", valid_rx_out, 0);
    chk("glitch_ferr_n", ferr_n, m_ferr);
    fork
      send_frame(8'h3C, 0, 0, 40, c);
      begin tick(190); chk("break_busy", busy_rx_out, 1); end
    join
    model_frame(8'h3C, 0, 0, c);
    chk("break_exit", busy_rx_out, 0);
    frame(8'h55, 1, 0);
    set_ready(0);
    frame(8'h11, 1, 0);
    frame(8'h22, 1, 0);
    set_ready(1);
    tick(1);
    ready_rx_in = 0;
    chk("hs_valid", valid_rx_out, 0);
`ifdef UART_RX_PARITY_EN
    set_ready(1);
    frame(8'h07, 1, 1);
    frame(8'h07, 1, 0);
`endif
    for (int i = 0; i < 14; i++) begin
      d = BS'($urandom);
      st = $urandom_range(0, 5) != 0;
      pb = 0;
`ifdef UART_RX_PARITY_EN
      pb = $urandom_range(0, 3) == 0;
`endif
      set_ready(logic'($urandom_range(0, 1)));
      frame(d, st, pb);
    end
    set_ready(0);
    frame(8'h5A, 1, 0);
    sdata_rx_in = 0;
    tick(OS);
    for (int i = 0; i < 4; i++) begin sdata_rx_in = logic'(i != 1); tick(OS); end
    nreset = 0;
    sdata_rx_in = 1;
    #1;
    m_pend = 0;
    m_last = 0;
    chk("mid_rst_data", data_rx_out, 0);
    chk("mid_rst_valid", valid_rx_out, 0);
    chk("mid_rst_busy", busy_rx_out, 0);
    chk("mid_rst_ovr", overrun_err_out, 0);
    tick(2);
    nreset = 1;
    tick(4);
    set_ready(1);
    frame(8'hC3, 1, 0);
    chk("words_n", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("word", got_q[i], exp_q[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
